pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the instruction-fetch path. It drives the instruction-memory address and is stepped by the control state machine. Beyond plain increment it supports absolute jump, signed relative branch, and call/return through an internal LIFO return-address stack. It also offers a selectable wrap or halt-at-end policy and a sticky error flag.

---
 rtl/pc_pkg.sv | 30 +++
 rtl/return_stack.sv | 45 ++++
 rtl/pc_sequencer.sv | 115 +++++++++++
 tb/tb_pc_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types for the program-counter sequencer: command encoding and
// the priority decode that picks the single command acting in a cycle.
package pc_pkg;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_INC,
        OP_BRANCH,
        OP_JUMP,
        OP_CALL,
        OP_RET
    } pc_op_t;

    // ret > call > jump > branch > up; nothing asserted means hold.
    function automatic pc_op_t decode_op(
        input logic ret,
        input logic call,
        input logic jump,
        input logic branch,
        input logic up
    );
        if (ret)         return OP_RET;
        else if (call)   return OP_CALL;
        else if (jump)   return OP_JUMP;
        else if (branch) return OP_BRANCH;
        else if (up)     return OP_INC;
        else             return OP_HOLD;
    endfunction

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses. Only the occupancy count is reset; entry
// contents are don't-care until pushed.
module return_stack #(
    parameter int AW    = 7,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_data,
    output logic [AW-1:0] top,
    output logic [CW-1:0] count
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] mem [DEPTH];
    logic [IW-1:0] top_idx;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign top_idx = IW'(count - CW'(1));
    assign top     = mem[top_idx];

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            count <= '0;
        end else if (do_push) begin
            count <= count + CW'(1);
        end else if (do_pop) begin
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[IW'(count)] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-fetch program counter: increment, absolute jump, relative
// branch, call/return via return_stack, with wrap or halt-at-end policy.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int AW         = 7,
    parameter int DEPTH      = 4,
    parameter int WRAP       = 1,
    parameter int LAST_ADDR  = 2**AW - 1,
    parameter int RESET_ADDR = 0,
    parameter int OW         = 5,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          up,
    input  logic          jump,
    input  logic [AW-1:0] jump_addr,
    input  logic          branch,
    input  logic [OW-1:0] branch_off,
    input  logic          call,
    input  logic          ret,
    output logic [AW-1:0] address,
    output logic [CW-1:0] stack_count,
    output logic          stack_full,
    output logic          stack_empty,
    output logic          halted,
    output logic          err
);

    localparam logic [AW-1:0] LAST  = AW'(LAST_ADDR);
    localparam logic [AW-1:0] START = AW'(RESET_ADDR);

    pc_op_t        op;
    logic [AW-1:0] incr;
    logic [AW-1:0] top;
    logic [AW:0]   target;
    logic          branch_bad;
    logic          push;
    logic          pop;

    assign op          = decode_op(ret, call, jump, branch, up);
    assign incr        = address + AW'(1);
    assign stack_full  = (stack_count == CW'(DEPTH));
    assign stack_empty = (stack_count == '0);
    assign push        = (op == OP_CALL) && !stack_full;
    assign pop         = (op == OP_RET) && !stack_empty;

    // One extra bit so a negative result or overshoot past the top shows up in target[AW].
    assign target     = {1'b0, address} + {{(AW + 1 - OW){branch_off[OW-1]}}, branch_off};
    assign branch_bad = (WRAP == 0) && (target[AW] || (target[AW-1:0] > LAST));

    return_stack #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk       (clk),
        .clear     (clear),
        .push      (push),
        .pop       (pop),
        .push_data (incr),
        .top       (top),
        .count     (stack_count)
    );

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            address <= START;
            halted  <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (op)
                OP_INC: begin
                    if (!halted) begin
                        if ((WRAP == 0) && (address == LAST)) begin
                            halted <= 1'b1;
                        end else begin
                            address <= incr;
                        end
                    end
                end
                OP_JUMP: begin
                    address <= jump_addr;
                    halted  <= 1'b0;
                end
                OP_BRANCH: begin
                    if (branch_bad) begin
                        err <= 1'b1;
                    end else begin
                        address <= target[AW-1:0];
                        halted  <= 1'b0;
                    end
                end
                OP_CALL: begin
                    if (stack_full) begin
                        err <= 1'b1;
                    end else begin
                        address <= jump_addr;
                        halted  <= 1'b0;
                    end
                end
                OP_RET: begin
                    if (stack_empty) begin
                        err <= 1'b1;
                    end else begin
                        address <= top;
                        halted  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a wrapping and a halting instance share one
// command stream; expectations are hand-written per vector.
module tb_pc_sequencer;

    localparam int AW    = 7;
    localparam int OW    = 5;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct {
        int u, j, b, c, r;
        int ja, off;
        int aw, ah, cnt, ew, eh, hh;
    } vec_t;

    logic          clk = 1'b0;
    logic          clear;
    logic          up, jump, branch, call, ret;
    logic [AW-1:0] jump_addr;
    logic [OW-1:0] branch_off;

    logic [AW-1:0] address_w, address_h;
    logic [CW-1:0] count_w, count_h;
    logic          full_w, full_h, empty_w, empty_h;
    logic          halted_w, halted_h, err_w, err_h;

    int   checks   = 0;
    int   failures = 0;
    vec_t tbl[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    pc_sequencer #(
        .AW(AW), .DEPTH(DEPTH), .WRAP(1), .LAST_ADDR(127), .RESET_ADDR(0), .OW(OW)
    ) dut_w (
        .clk(clk), .clear(clear), .up(up), .jump(jump), .jump_addr(jump_addr),
        .branch(branch), .branch_off(branch_off), .call(call), .ret(ret),
        .address(address_w), .stack_count(count_w), .stack_full(full_w),
        .stack_empty(empty_w), .halted(halted_w), .err(err_w)
    );

    pc_sequencer #(
        .AW(AW), .DEPTH(DEPTH), .WRAP(0), .LAST_ADDR(127), .RESET_ADDR(0), .OW(OW)
    ) dut_h (
        .clk(clk), .clear(clear), .up(up), .jump(jump), .jump_addr(jump_addr),
        .branch(branch), .branch_off(branch_off), .call(call), .ret(ret),
        .address(address_h), .stack_count(count_h), .stack_full(full_h),
        .stack_empty(empty_h), .halted(halted_h), .err(err_h)
    );

    function automatic vec_t mk(int u, int j, int b, int c, int r, int ja, int off,
                                int aw, int ah, int cnt, int ew, int eh, int hh);
        vec_t v;
        v.u = u; v.j = j; v.b = b; v.c = c; v.r = r; v.ja = ja; v.off = off;
        v.aw = aw; v.ah = ah; v.cnt = cnt; v.ew = ew; v.eh = eh; v.hh = hh;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input vec_t e);
        chk({name, " addr_w"},   32'(address_w), e.aw);
        chk({name, " addr_h"},   32'(address_h), e.ah);
        chk({name, " count_w"},  32'(count_w),   e.cnt);
        chk({name, " count_h"},  32'(count_h),   e.cnt);
        chk({name, " full_w"},   32'(full_w),    (e.cnt == DEPTH) ? 1 : 0);
        chk({name, " full_h"},   32'(full_h),    (e.cnt == DEPTH) ? 1 : 0);
        chk({name, " empty_w"},  32'(empty_w),   (e.cnt == 0) ? 1 : 0);
        chk({name, " empty_h"},  32'(empty_h),   (e.cnt == 0) ? 1 : 0);
        chk({name, " err_w"},    32'(err_w),     e.ew);
        chk({name, " err_h"},    32'(err_h),     e.eh);
        chk({name, " halted_w"}, 32'(halted_w),  0);
        chk({name, " halted_h"}, 32'(halted_h),  e.hh);
    endtask

    task automatic idle_cmds();
        up = 1'b0; jump = 1'b0; branch = 1'b0; call = 1'b0; ret = 1'b0;
        jump_addr = '0; branch_off = '0;
    endtask

    // Drive one command, queue its expectation, compare after the edge.
    task automatic step(input string name, input vec_t v);
        vec_t e;
        @(negedge clk);
        up = (v.u != 0); jump = (v.j != 0); branch = (v.b != 0);
        call = (v.c != 0); ret = (v.r != 0);
        jump_addr = AW'(v.ja); branch_off = OW'(v.off);
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({name, " scoreboard_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk_all(name, e);
        end
    endtask

    initial begin
        clear = 1'b1;
        idle_cmds();
        repeat (2) @(negedge clk);
        chk_all("reset", mk(0,0,0,0,0,0,0, 0,0,0,0,0,0));
        clear = 1'b0;

        // Count up from 5, then clear between edges.
        step("t1_jump5", mk(0,1,0,0,0, 5,0, 5,5,0,0,0,0));
        step("t1_up6",   mk(1,0,0,0,0, 0,0, 6,6,0,0,0,0));
        step("t1_up7",   mk(1,0,0,0,0, 0,0, 7,7,0,0,0,0));
        #1;
        clear = 1'b1;
        idle_cmds();
        #1;
        chk_all("t1_async_clear", mk(0,0,0,0,0,0,0, 0,0,0,0,0,0));
        @(negedge clk);
        clear = 1'b0;

        //          u j b c r  ja  off   aw  ah cnt ew eh hh
        tbl.push_back(mk(0,1,0,0,0, 126,  0, 126,126, 0, 0, 0, 0));
        tbl.push_back(mk(1,0,0,0,0,   0,  0, 127,127, 0, 0, 0, 0));
        tbl.push_back(mk(1,0,0,0,0,   0,  0,   0,127, 0, 0, 0, 1));
        tbl.push_back(mk(1,0,0,0,0,   0,  0,   1,127, 0, 0, 0, 1));
        tbl.push_back(mk(0,1,0,0,0,  10,  0,  10, 10, 0, 0, 0, 0));
        tbl.push_back(mk(0,1,0,0,0,  20,  0,  20, 20, 0, 0, 0, 0));
        tbl.push_back(mk(0,0,1,0,0,   0, -5,  15, 15, 0, 0, 0, 0));
        tbl.push_back(mk(0,1,0,0,0, 120,  0, 120,120, 0, 0, 0, 0));
        tbl.push_back(mk(0,0,1,0,0,   0,  7, 127,127, 0, 0, 0, 0));
        tbl.push_back(mk(1,0,0,0,0,   0,  0,   0,127, 0, 0, 0, 1));
        tbl.push_back(mk(0,0,1,0,0,   0, -1, 127,126, 0, 0, 0, 0));
        tbl.push_back(mk(0,1,0,0,0, 125,  0, 125,125, 0, 0, 0, 0));
        tbl.push_back(mk(0,0,1,0,0,   0,  6,   3,125, 0, 0, 1, 0));
        tbl.push_back(mk(0,1,0,0,0,   2,  0,   2,  2, 0, 0, 1, 0));
        tbl.push_back(mk(0,0,1,0,0,   0, -5, 125,  2, 0, 0, 1, 0));
        tbl.push_back(mk(0,1,0,0,0,  10,  0,  10, 10, 0, 0, 1, 0));
        tbl.push_back(mk(0,0,0,1,0,  40,  0,  40, 40, 1, 0, 1, 0));
        tbl.push_back(mk(0,0,0,1,0,  60,  0,  60, 60, 2, 0, 1, 0));
        tbl.push_back(mk(0,0,0,0,1,   0,  0,  41, 41, 1, 0, 1, 0));
        tbl.push_back(mk(0,0,0,0,1,   0,  0,  11, 11, 0, 0, 1, 0));
        tbl.push_back(mk(0,0,0,0,1,   0,  0,  11, 11, 0, 1, 1, 0));
        tbl.push_back(mk(0,0,0,1,0,  30,  0,  30, 30, 1, 1, 1, 0));
        tbl.push_back(mk(0,0,0,1,0,  40,  0,  40, 40, 2, 1, 1, 0));
        tbl.push_back(mk(0,0,0,1,0,  50,  0,  50, 50, 3, 1, 1, 0));
        tbl.push_back(mk(0,0,0,1,0,  60,  0,  60, 60, 4, 1, 1, 0));
        tbl.push_back(mk(0,0,0,1,0,  70,  0,  60, 60, 4, 1, 1, 0));
        tbl.push_back(mk(1,0,0,1,1,   5,  0,  51, 51, 3, 1, 1, 0));
        tbl.push_back(mk(0,0,0,0,1,   0,  0,  41, 41, 2, 1, 1, 0));
        tbl.push_back(mk(1,1,1,0,0, 100,  3, 100,100, 2, 1, 1, 0));
        tbl.push_back(mk(1,0,1,0,0,   0, -4,  96, 96, 2, 1, 1, 0));
        tbl.push_back(mk(1,0,0,0,0,   0,  0,  97, 97, 2, 1, 1, 0));
        tbl.push_back(mk(0,0,0,0,0,   0,  0,  97, 97, 2, 1, 1, 0));
        tbl.push_back(mk(0,1,0,1,0,  33,  0,  33, 33, 3, 1, 1, 0));
        tbl.push_back(mk(0,0,0,0,1,   0,  0,  98, 98, 2, 1, 1, 0));

        foreach (tbl[i]) begin
            step($sformatf("v%0d", i), tbl[i]);
        end

        // Clear with a loaded stack and sticky err set, then resume.
        #1;
        clear = 1'b1;
        idle_cmds();
        #1;
        chk_all("clear_loaded", mk(0,0,0,0,0,0,0, 0,0,0,0,0,0));
        @(negedge clk);
        clear = 1'b0;
        step("resume_up", mk(1,0,0,0,0, 0,0, 1,1,0,0,0,0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
